// File: rtl/dff_ser_pkg.sv
// ----------------------------------------------------------------------------
// dff_ser_pkg
//   Shared definitions for the word serializer:
//     - FSM state encoding (S_IDLE / S_SHIFT)
//     - cnt_width(): width of the slice index; never less than 1 bit so
//       that a single-slice configuration still has a legal counter.
// ----------------------------------------------------------------------------
package dff_ser_pkg;

   localparam logic S_IDLE  = 1'b0;
   localparam logic S_SHIFT = 1'b1;

   function automatic int cnt_width(input int n);
      return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/general_dff.sv
// ----------------------------------------------------------------------------
// general_dff
//   Load-enabled word register with asynchronous active-low clear.
//   Ports:
//     clk, rst_n   clock / async active-low reset
//     i_ld_en      capture i_d on the next rising edge
//     i_d          data in  (WIDTH bits)
//     o_q          data out (WIDTH bits)
// ----------------------------------------------------------------------------
module general_dff #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ld_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Word storage: load on enable, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_ld_en) begin
         r_q <= i_d;
      end else begin
         r_q <= r_q;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/ser_slice_cnt.sv
// ----------------------------------------------------------------------------
// ser_slice_cnt
//   Slice index counter that saturates at NUM_SLICES-1 (never wraps).
//   Ports:
//     clk, rst_n   clock / async active-low reset
//     i_clr        return index to 0 (has priority over i_inc)
//     i_inc        advance index by one unless already on the last slice
//     o_cnt        current slice index
//     o_is_last    index points at the final slice
// ----------------------------------------------------------------------------
module ser_slice_cnt
   import dff_ser_pkg::*;
#(
   parameter int NUM_SLICES = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_clr,
   input  logic                            i_inc,
   output logic [cnt_width(NUM_SLICES)-1:0] o_cnt,
   output logic                            o_is_last
);

   localparam int CW = cnt_width(NUM_SLICES);

   logic [CW-1:0] r_cnt;
   logic          w_is_last;

   assign w_is_last = (r_cnt == CW'(NUM_SLICES - 1));

   // Slice index: clear, saturating increment, or hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !w_is_last) begin
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt     = r_cnt;
   assign o_is_last = w_is_last;

endmodule

// File: rtl/dff_word_serializer.sv
// ----------------------------------------------------------------------------
// dff_word_serializer
//   Captures a DATA_WIDTH word over valid/ready and drains it as
//   NUM_SLICES = DATA_WIDTH/SLICE_WIDTH slices over a valid/ready/last stream.
//   DATA_WIDTH must be a whole multiple of SLICE_WIDTH.
//
//   Build option (macro SER_MSB_FIRST_EN):
//     defined   -> most significant slice is sent first
//     undefined -> least significant slice is sent first (default)
//
//   Ports:
//     clk, rst_n   clock / async active-low reset
//     in_valid     in_data is valid
//     in_ready     block can capture a word (IDLE only)
//     in_data      parallel word
//     out_valid    out_data holds a valid slice
//     out_ready    downstream accepts the slice
//     out_data     current slice (0 while idle)
//     out_last     current slice is the final slice of the word
//     busy         word held and not fully drained
//
//   Every output is a decode of r_state, the held word and the slice counter;
//   in_valid/out_ready only influence next-state logic.
// ----------------------------------------------------------------------------
module dff_word_serializer
   import dff_ser_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SLICE_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SLICE_WIDTH-1:0] out_data,
   output logic                   out_last,
   output logic                   busy
);

   localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
   localparam int CW         = cnt_width(NUM_SLICES);

   logic                   r_state;
   logic                   w_next_state;
   logic [DATA_WIDTH-1:0]  r_word;
   logic                   w_load;
   logic                   w_out_hs;
   logic [CW-1:0]          w_cnt;
   logic                   w_is_last;
   logic [SLICE_WIDTH-1:0] w_slices [NUM_SLICES];
   logic [SLICE_WIDTH-1:0] w_sel_slice;

   assign w_load   = in_valid && in_ready;
   assign w_out_hs = out_valid && out_ready;

   general_dff #(
      .WIDTH (DATA_WIDTH)
   ) u_word (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ld_en (w_load),
      .i_d     (in_data),
      .o_q     (r_word)
   );

   // Clearing on the final handshake leaves the counter at 0 while idle.
   ser_slice_cnt #(
      .NUM_SLICES (NUM_SLICES)
   ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_load || (w_out_hs && w_is_last)),
      .i_inc     (w_out_hs && !w_is_last),
      .o_cnt     (w_cnt),
      .o_is_last (w_is_last)
   );

   // Slice k view of the held word; order fixed at build time.
   for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
`ifdef SER_MSB_FIRST_EN
      assign w_slices[k] = r_word[DATA_WIDTH-1-k*SLICE_WIDTH -: SLICE_WIDTH];
`else
      assign w_slices[k] = r_word[k*SLICE_WIDTH +: SLICE_WIDTH];
`endif
   end

   // Slice mux: one-hot OR keeps the index width independent of array size.
   always_comb begin
      w_sel_slice = '0;
      for (int k = 0; k < NUM_SLICES; k++) begin
         w_sel_slice = w_sel_slice | ((w_cnt == CW'(k)) ? w_slices[k] : '0);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  w_next_state = w_load ? S_SHIFT : S_IDLE;
         S_SHIFT: w_next_state = (w_out_hs && w_is_last) ? S_IDLE : S_SHIFT;
         default: w_next_state = S_IDLE;
      endcase
   end

   // FSM outputs: decoded from state and registered data only.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            out_data  = '0;
            out_last  = 1'b0;
            busy      = 1'b0;
         end
         S_SHIFT: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            out_data  = w_sel_slice;
            out_last  = w_is_last;
            busy      = 1'b1;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            out_data  = '0;
            out_last  = 1'b0;
            busy      = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dff_word_serializer.sv
// ----------------------------------------------------------------------------
// tb_dff_word_serializer
//   Directed, table-driven bench for dff_word_serializer (32/8) plus a
//   single-slice instance (32/32). Slice order expectations follow the
//   SER_MSB_FIRST_EN build option.
// ----------------------------------------------------------------------------
module tb_dff_word_serializer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic        busy;

   logic        w_iv;
   logic        w_ir;
   logic [31:0] w_data;
   logic        w_ov;
   logic        w_ordy;
   logic [31:0] w_od;
   logic        w_last;
   logic        w_busy;

   int n_checks;
   int n_fail;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic [7:0]  e_od;
      logic        e_last;
      logic        e_busy;
   } vec_t;

   vec_t vecs [19];

   dff_word_serializer #(
      .DATA_WIDTH  (32),
      .SLICE_WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   dff_word_serializer #(
      .DATA_WIDTH  (32),
      .SLICE_WIDTH (32)
   ) dut_wide (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_iv),
      .in_ready  (w_ir),
      .in_data   (w_data),
      .out_valid (w_ov),
      .out_ready (w_ordy),
      .out_data  (w_od),
      .out_last  (w_last),
      .busy      (w_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected slice k of a word for the selected build order.
   function automatic logic [7:0] exp_slice(input logic [31:0] w, input int k);
`ifdef SER_MSB_FIRST_EN
      return w[31-8*k -: 8];
`else
      return w[8*k +: 8];
`endif
   endfunction

   function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic ordy,
                               input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                               input logic e_last, input logic e_busy);
      vec_t v;
      v.iv = iv; v.d = d; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_last = e_last; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic chk_narrow(input string tag, input int idx, input logic e_ir, input logic e_ov,
                             input logic [7:0] e_od, input logic e_last, input logic e_busy);
      chk({tag, ".in_ready"},  idx, {31'd0, in_ready},  {31'd0, e_ir});
      chk({tag, ".out_valid"}, idx, {31'd0, out_valid}, {31'd0, e_ov});
      chk({tag, ".out_data"},  idx, {24'd0, out_data},  {24'd0, e_od});
      chk({tag, ".out_last"},  idx, {31'd0, out_last},  {31'd0, e_last});
      chk({tag, ".busy"},      idx, {31'd0, busy},      {31'd0, e_busy});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] W_A = 32'hA1B2C3D4;
   localparam logic [31:0] W_N = 32'h11223344;
   localparam logic [31:0] W_R = 32'h0000FF00;
   localparam logic [31:0] W_W = 32'hCAFE0123;

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      out_ready = 1'b1;
      w_iv      = 1'b0;
      w_data    = 32'd0;
      w_ordy    = 1'b1;

      // Basic word, backpressure on slice 1, input offered while busy.
      vecs[0]  = mk(1'b1, W_A,   1'b1, 1'b1, 1'b0, 8'h00,             1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_A, 0), 1'b0, 1'b1);
      vecs[2]  = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_A, 1), 1'b0, 1'b1);
      vecs[3]  = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_A, 2), 1'b0, 1'b1);
      vecs[4]  = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_A, 3), 1'b1, 1'b1);
      vecs[5]  = mk(1'b1, W_A,   1'b1, 1'b1, 1'b0, 8'h00,             1'b0, 1'b0);
      vecs[6]  = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_A, 0), 1'b0, 1'b1);
      vecs[7]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, exp_slice(W_A, 1), 1'b0, 1'b1);
      vecs[8]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, exp_slice(W_A, 1), 1'b0, 1'b1);
      vecs[9]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, exp_slice(W_A, 1), 1'b0, 1'b1);
      vecs[10] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_A, 1), 1'b0, 1'b1);
      vecs[11] = mk(1'b1, W_N,   1'b1, 1'b0, 1'b1, exp_slice(W_A, 2), 1'b0, 1'b1);
      vecs[12] = mk(1'b1, W_N,   1'b1, 1'b0, 1'b1, exp_slice(W_A, 3), 1'b1, 1'b1);
      vecs[13] = mk(1'b1, W_N,   1'b1, 1'b1, 1'b0, 8'h00,             1'b0, 1'b0);
      vecs[14] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_N, 0), 1'b0, 1'b1);
      vecs[15] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_N, 1), 1'b0, 1'b1);
      vecs[16] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_N, 2), 1'b0, 1'b1);
      vecs[17] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, exp_slice(W_N, 3), 1'b1, 1'b1);
      vecs[18] = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 8'h00,             1'b0, 1'b0);

      // Reset values while rst_n is held low.
      #12;
      chk_narrow("reset", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;

      // Table-driven cycles: inputs applied after an edge, outputs checked at negedge.
      for (int i = 0; i < 19; i++) begin
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].d;
         out_ready = vecs[i].ordy;
         @(negedge clk);
         chk_narrow("vec", i, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_od,
                    vecs[i].e_last, vecs[i].e_busy);
         tick();
      end

      // Reset mid-operation: three slices drained, reset during the fourth.
      in_valid  = 1'b1;
      in_data   = W_A;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_data   = 32'd0;
      tick();
      tick();
      tick();
      chk_narrow("pre_rst", 0, 1'b0, 1'b1, exp_slice(W_A, 3), 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_narrow("mid_rst", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk_narrow("post_rst", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      in_valid = 1'b1;
      in_data  = W_R;
      tick();
      in_valid = 1'b0;
      in_data  = 32'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk_narrow("rst_word", k, 1'b0, 1'b1, exp_slice(W_R, k), (k == 3), 1'b1);
         tick();
      end
      @(negedge clk);
      chk_narrow("rst_done", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // Single-slice instance: one beat carrying the whole word, last set.
      tick();
      chk("wide.idle_ready", 0, {31'd0, w_ir}, 32'd1);
      chk("wide.idle_valid", 0, {31'd0, w_ov}, 32'd0);
      w_iv   = 1'b1;
      w_data = W_W;
      tick();
      w_iv   = 1'b0;
      w_data = 32'd0;
      @(negedge clk);
      chk("wide.valid", 0, {31'd0, w_ov},   32'd1);
      chk("wide.data",  0, w_od,            W_W);
      chk("wide.last",  0, {31'd0, w_last}, 32'd1);
      chk("wide.busy",  0, {31'd0, w_busy}, 32'd1);
      chk("wide.ready", 0, {31'd0, w_ir},   32'd0);
      tick();
      @(negedge clk);
      chk("wide.done_valid", 0, {31'd0, w_ov},   32'd0);
      chk("wide.done_ready", 0, {31'd0, w_ir},   32'd1);
      chk("wide.done_busy",  0, {31'd0, w_busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
